// File: rtl/riscv_pkg.sv
// Shared RV32I decode definitions: opcodes, immediate formats, ALU codes and the ID/EX record.
package riscv_pkg;

    localparam int XLEN      = 32;
    localparam int REG_COUNT = 32;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    localparam logic [1:0] RES_ALU = 2'b00;
    localparam logic [1:0] RES_MEM = 2'b01;
    localparam logic [1:0] RES_PC4 = 2'b10;

    typedef enum logic [1:0] {
        IMM_I = 2'b00,
        IMM_S = 2'b01,
        IMM_B = 2'b10,
        IMM_J = 2'b11
    } imm_src_e;

    typedef enum logic [1:0] {
        ALUOP_ADD   = 2'b00,
        ALUOP_SUB   = 2'b01,
        ALUOP_FUNCT = 2'b10
    } alu_op_e;

    typedef enum logic [2:0] {
        ALU_ADD = 3'b000,
        ALU_SUB = 3'b001,
        ALU_AND = 3'b010,
        ALU_OR  = 3'b011,
        ALU_SLT = 3'b101
    } alu_ctrl_e;

    typedef struct packed {
        logic            reg_write;
        logic            mem_write;
        logic            alu_src;
        logic            branch;
        logic            jump;
        logic [1:0]      result_src;
        alu_ctrl_e       alu_ctrl;
        logic [XLEN-1:0] rd1;
        logic [XLEN-1:0] rd2;
        logic [XLEN-1:0] imm;
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] pc_plus4;
        logic [4:0]      rs1;
        logic [4:0]      rs2;
        logic [4:0]      rd;
    } idex_t;

    // Opcodes without an immediate leave the selector at IMM_I, so they extend instr[31:20].
    function automatic logic [XLEN-1:0] imm_extend(input logic [31:0] instr, input imm_src_e src);
        logic [XLEN-1:0] imm;
        case (src)
            IMM_S:   imm = {{20{instr[31]}}, instr[31:25], instr[11:7]};
            IMM_B:   imm = {{20{instr[31]}}, instr[7], instr[30:25], instr[11:8], 1'b0};
            IMM_J:   imm = {{12{instr[31]}}, instr[19:12], instr[20], instr[30:21], 1'b0};
            default: imm = {{20{instr[31]}}, instr[31:20]};
        endcase
        return imm;
    endfunction

endpackage

// File: rtl/register_file.sv
// 32x32 register file: synchronous write, asynchronous read, x0 reads as zero.
// Optional same-cycle write-to-read forwarding under REGFILE_BYPASS_EN.
module register_file #(
    parameter int XLEN      = 32,
    parameter int REG_COUNT = 32,
    parameter int AW        = $clog2(REG_COUNT)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [AW-1:0]   a1,
    input  logic [AW-1:0]   a2,
    input  logic            we3,
    input  logic [AW-1:0]   a3,
    input  logic [XLEN-1:0] wd3,
    output logic [XLEN-1:0] rd1,
    output logic [XLEN-1:0] rd2
);

    logic [XLEN-1:0] regs_q [REG_COUNT];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < REG_COUNT; i++) begin
                regs_q[i] <= '0;
            end
        end else if (we3 && (a3 != '0)) begin
            regs_q[a3] <= wd3;
        end
    end

    always_comb begin
        rd1 = regs_q[a1];
`ifdef REGFILE_BYPASS_EN
        if (we3 && (a3 == a1)) rd1 = wd3;
`endif
        if (a1 == '0) rd1 = '0;
    end

    always_comb begin
        rd2 = regs_q[a2];
`ifdef REGFILE_BYPASS_EN
        if (we3 && (a3 == a2)) rd2 = wd3;
`endif
        if (a2 == '0) rd2 = '0;
    end

endmodule

// File: rtl/decode_cycle.sv
// RV32I decode stage: register file, control/ALU decode, immediate extension and ID/EX register.
// REGFILE_BYPASS_EN enables same-cycle writeback forwarding inside the register file.
module decode_cycle
    import riscv_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic [31:0]      InstrD,
    input  logic [XLEN-1:0]  PCD,
    input  logic [XLEN-1:0]  PCPlus4D,
    input  logic             RegWriteW,
    input  logic [4:0]       RDW,
    input  logic [XLEN-1:0]  ResultW,
    input  logic             FlushE,
    output logic [4:0]       Rs1D,
    output logic [4:0]       Rs2D,
    output logic             RegWriteE,
    output logic             MemWriteE,
    output logic             ALUSrcE,
    output logic             BranchE,
    output logic             JumpE,
    output logic [1:0]       ResultSrcE,
    output logic [2:0]       ALUControlE,
    output logic [XLEN-1:0]  RD1_E,
    output logic [XLEN-1:0]  RD2_E,
    output logic [XLEN-1:0]  Imm_Ext_E,
    output logic [XLEN-1:0]  PCE,
    output logic [XLEN-1:0]  PCPlus4E,
    output logic [4:0]       RS1_E,
    output logic [4:0]       RS2_E,
    output logic [4:0]       RD_E
);

    logic [6:0]      op;
    logic [2:0]      funct3;
    logic            reg_write, mem_write, alu_src, branch, jump;
    logic [1:0]      result_src;
    imm_src_e        imm_src;
    alu_op_e         alu_op;
    alu_ctrl_e       alu_ctrl;
    logic [XLEN-1:0] rd1, rd2;
    idex_t           idex_d, idex_q;

    assign op     = InstrD[6:0];
    assign funct3 = InstrD[14:12];
    assign Rs1D   = InstrD[19:15];
    assign Rs2D   = InstrD[24:20];

    register_file #(.XLEN(XLEN), .REG_COUNT(REG_COUNT)) u_rf (
        .clk (clk),
        .rst (rst),
        .a1  (Rs1D),
        .a2  (Rs2D),
        .we3 (RegWriteW),
        .a3  (RDW),
        .wd3 (ResultW),
        .rd1 (rd1),
        .rd2 (rd2)
    );

    // Unknown opcodes, including the all-zero bubble, fall through as a no-op.
    always_comb begin
        reg_write  = 1'b0;
        mem_write  = 1'b0;
        alu_src    = 1'b0;
        branch     = 1'b0;
        jump       = 1'b0;
        result_src = RES_ALU;
        imm_src    = IMM_I;
        alu_op     = ALUOP_ADD;
        case (op)
            OP_LOAD: begin
                reg_write  = 1'b1;
                alu_src    = 1'b1;
                result_src = RES_MEM;
            end
            OP_STORE: begin
                mem_write = 1'b1;
                alu_src   = 1'b1;
                imm_src   = IMM_S;
            end
            OP_RTYPE: begin
                reg_write = 1'b1;
                alu_op    = ALUOP_FUNCT;
            end
            OP_ITYPE: begin
                reg_write = 1'b1;
                alu_src   = 1'b1;
                alu_op    = ALUOP_FUNCT;
            end
            OP_BRANCH: begin
                branch  = 1'b1;
                imm_src = IMM_B;
                alu_op  = ALUOP_SUB;
            end
            OP_JAL: begin
                reg_write  = 1'b1;
                jump       = 1'b1;
                result_src = RES_PC4;
                imm_src    = IMM_J;
            end
            default: ;
        endcase
    end

    // Subtract only for R-type with funct7[5]; addi must never become a subtract.
    always_comb begin
        alu_ctrl = ALU_ADD;
        case (alu_op)
            ALUOP_ADD: alu_ctrl = ALU_ADD;
            ALUOP_SUB: alu_ctrl = ALU_SUB;
            default: begin
                case (funct3)
                    3'b000:  alu_ctrl = (op[5] && InstrD[30]) ? ALU_SUB : ALU_ADD;
                    3'b010:  alu_ctrl = ALU_SLT;
                    3'b110:  alu_ctrl = ALU_OR;
                    3'b111:  alu_ctrl = ALU_AND;
                    default: alu_ctrl = ALU_ADD;
                endcase
            end
        endcase
    end

    always_comb begin
        idex_d            = '0;
        idex_d.reg_write  = reg_write;
        idex_d.mem_write  = mem_write;
        idex_d.alu_src    = alu_src;
        idex_d.branch     = branch;
        idex_d.jump       = jump;
        idex_d.result_src = result_src;
        idex_d.alu_ctrl   = alu_ctrl;
        idex_d.rd1        = rd1;
        idex_d.rd2        = rd2;
        idex_d.imm        = imm_extend(InstrD, imm_src);
        idex_d.pc         = PCD;
        idex_d.pc_plus4   = PCPlus4D;
        idex_d.rs1        = Rs1D;
        idex_d.rs2        = Rs2D;
        idex_d.rd         = InstrD[11:7];
    end

    always_ff @(posedge clk) begin
        if (rst || FlushE) begin
            idex_q <= '0;
        end else begin
            idex_q <= idex_d;
        end
    end

    assign RegWriteE   = idex_q.reg_write;
    assign MemWriteE   = idex_q.mem_write;
    assign ALUSrcE     = idex_q.alu_src;
    assign BranchE     = idex_q.branch;
    assign JumpE       = idex_q.jump;
    assign ResultSrcE  = idex_q.result_src;
    assign ALUControlE = idex_q.alu_ctrl;
    assign RD1_E       = idex_q.rd1;
    assign RD2_E       = idex_q.rd2;
    assign Imm_Ext_E   = idex_q.imm;
    assign PCE         = idex_q.pc;
    assign PCPlus4E    = idex_q.pc_plus4;
    assign RS1_E       = idex_q.rs1;
    assign RS2_E       = idex_q.rs2;
    assign RD_E        = idex_q.rd;

endmodule

// File: tb/tb_decode_cycle.sv
// Self-checking bench for decode_cycle; expected ID/EX contents are queued when driven and compared one edge later.
module tb_decode_cycle;

    localparam int VW = 185;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] InstrD, PCD, PCPlus4D, ResultW;
    logic        RegWriteW, FlushE;
    logic [4:0]  RDW;
    logic [4:0]  Rs1D, Rs2D, RS1_E, RS2_E, RD_E;
    logic        RegWriteE, MemWriteE, ALUSrcE, BranchE, JumpE;
    logic [1:0]  ResultSrcE;
    logic [2:0]  ALUControlE;
    logic [31:0] RD1_E, RD2_E, Imm_Ext_E, PCE, PCPlus4E;

    always #5 clk = ~clk;

    decode_cycle dut (
        .clk(clk), .rst(rst), .InstrD(InstrD), .PCD(PCD), .PCPlus4D(PCPlus4D),
        .RegWriteW(RegWriteW), .RDW(RDW), .ResultW(ResultW), .FlushE(FlushE),
        .Rs1D(Rs1D), .Rs2D(Rs2D),
        .RegWriteE(RegWriteE), .MemWriteE(MemWriteE), .ALUSrcE(ALUSrcE),
        .BranchE(BranchE), .JumpE(JumpE), .ResultSrcE(ResultSrcE), .ALUControlE(ALUControlE),
        .RD1_E(RD1_E), .RD2_E(RD2_E), .Imm_Ext_E(Imm_Ext_E), .PCE(PCE), .PCPlus4E(PCPlus4E),
        .RS1_E(RS1_E), .RS2_E(RS2_E), .RD_E(RD_E)
    );

    // Packed view of every E output: {ctrl[9:0], rd1, rd2, imm, pc, pc4, rs1, rs2, rd}
    wire [VW-1:0] act_vec = {RegWriteE, MemWriteE, ALUSrcE, BranchE, JumpE, ResultSrcE, ALUControlE,
                             RD1_E, RD2_E, Imm_Ext_E, PCE, PCPlus4E, RS1_E, RS2_E, RD_E};

    logic [VW-1:0] exp_q[$];
    logic [VW-1:0] exp;
    logic [31:0]   ref_rf [32];
    int            n_tests = 0;
    int            n_fail  = 0;

    // ctrl = {RegWrite, MemWrite, ALUSrc, Branch, Jump, ResultSrc[1:0], ALUControl[2:0]}
    logic [31:0] tbl_instr [11];
    logic [9:0]  tbl_ctrl  [11];
    logic [31:0] tbl_imm   [11];

    task automatic init_table();
        tbl_instr = '{32'h406204B3, 32'h006224B3, 32'h006264B3, 32'h006274B3, 32'h006244B3,
                      32'hC0020493, 32'hFF822483, 32'h001000EF, 32'hFFDFF06F, 32'h00620463,
                      32'hFE622E23};
        tbl_ctrl  = '{10'b1000000001, 10'b1000000101, 10'b1000000011, 10'b1000000010, 10'b1000000000,
                      10'b1010000000, 10'b1010001000, 10'b1000110000, 10'b1000110000, 10'b0001000001,
                      10'b0110000000};
        tbl_imm   = '{32'h00000406, 32'h00000006, 32'h00000006, 32'h00000006, 32'h00000006,
                      32'hFFFFFC00, 32'hFFFFFFF8, 32'h00000800, 32'hFFFFFFFC, 32'h00000008,
                      32'hFFFFFFFC};
    endtask

    function automatic logic [31:0] rf_read(input logic [4:0] idx);
        if (idx == 5'd0) return 32'd0;
`ifdef REGFILE_BYPASS_EN
        if (RegWriteW && (RDW == idx)) return ResultW;
`endif
        return ref_rf[idx];
    endfunction

    task automatic drive(input logic [31:0] instr, input logic [9:0] ctrl, input logic [31:0] imm,
                         input logic [31:0] pc, input logic flush, input logic rstv,
                         input logic we, input logic [4:0] rdw, input logic [31:0] wd);
        logic [31:0] pc4;
        pc4 = pc + 32'd4;
        InstrD = instr; PCD = pc; PCPlus4D = pc4; FlushE = flush; rst = rstv;
        RegWriteW = we; RDW = rdw; ResultW = wd;
        if (rstv || flush) exp_q.push_back('0);
        else exp_q.push_back({ctrl, rf_read(instr[19:15]), rf_read(instr[24:20]), imm, pc, pc4,
                              instr[19:15], instr[24:20], instr[11:7]});
    endtask

    task automatic clock_edge();
        @(posedge clk);
        if (rst) begin
            for (int i = 0; i < 32; i++) ref_rf[i] = 32'd0;
        end else if (RegWriteW && (RDW != 5'd0)) begin
            ref_rf[RDW] = ResultW;
        end
        #1;
    endtask

    function automatic logic [31:0] i_imm(input logic [31:0] instr);
        return {{20{instr[31]}}, instr[31:20]};
    endfunction

    task automatic test_reset();
        logic [31:0] ins;
        drive(32'h0, 10'd0, 32'd0, 32'd0, 1'b0, 1'b1, 1'b0, 5'd0, 32'd0);
        clock_edge();
        exp = exp_q.pop_front(); n_tests++;
        if (act_vec !== exp) begin n_fail++; $display("FAIL reset_init: got %h want %h", act_vec, exp); end
        for (int i = 0; i < 6; i++) begin
            ins = $urandom() & 32'hFFFF_FF80;
            drive(ins, 10'd0, i_imm(ins), $urandom(), 1'b0, 1'b0, 1'b1,
                  5'($urandom_range(1, 31)), $urandom());
            clock_edge();
            exp = exp_q.pop_front(); n_tests++;
            if (act_vec !== exp) begin n_fail++; $display("FAIL reset_seed[%0d]: got %h want %h", i, act_vec, exp); end
        end
        for (int i = 0; i < 2; i++) begin
            drive(tbl_instr[i + 5], tbl_ctrl[i + 5], tbl_imm[i + 5], $urandom(), 1'b1, 1'b1,
                  1'b1, 5'd3, 32'hFFFF_FFFF);
            clock_edge();
            exp = exp_q.pop_front(); n_tests++;
            if (act_vec !== exp) begin n_fail++; $display("FAIL reset_hold[%0d]: got %h want %h", i, act_vec, exp); end
        end
        for (int i = 1; i < 32; i++) begin
            ins = {7'd0, 5'(32 - i), 5'(i), 3'd0, 5'd0, 7'd0};
            drive(ins, 10'd0, i_imm(ins), 32'h200 + 32'(i * 4), 1'b0, 1'b0, 1'b0, 5'd0, 32'd0);
            n_tests++;
            if (Rs1D !== 5'(i) || Rs2D !== 5'(32 - i)) begin
                n_fail++; $display("FAIL rs_fields[%0d]: got %0d/%0d want %0d/%0d", i, Rs1D, Rs2D, i, 32 - i);
            end
            clock_edge();
            exp = exp_q.pop_front(); n_tests++;
            if (act_vec !== exp) begin n_fail++; $display("FAIL reset_read[%0d]: got %h want %h", i, act_vec, exp); end
        end
    endtask

    task automatic test_addi();
        drive(32'h0, 10'd0, 32'd0, 32'h0FC, 1'b0, 1'b0, 1'b1, 5'd5, 32'h0000_00AA);
        clock_edge();
        exp = exp_q.pop_front(); n_tests++;
        if (act_vec !== exp) begin n_fail++; $display("FAIL addi_write: got %h want %h", act_vec, exp); end
        drive(32'h0052_8313, 10'b1010000000, 32'd5, 32'h100, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0);
        clock_edge();
        exp = exp_q.pop_front(); n_tests++;
        if (act_vec !== exp) begin n_fail++; $display("FAIL addi: got %h want %h", act_vec, exp); end
        n_tests++;
        if (RD1_E !== 32'hAA || RD_E !== 5'd6) begin
            n_fail++; $display("FAIL addi_fields: got rd1=%h rd=%0d want rd1=aa rd=6", RD1_E, RD_E);
        end
    endtask

    task automatic test_beq();
        drive(32'h0, 10'd0, 32'd0, 32'h0, 1'b0, 1'b0, 1'b1, 5'd4, 32'h0000_0044);
        clock_edge();
        exp = exp_q.pop_front(); n_tests++;
        if (act_vec !== exp) begin n_fail++; $display("FAIL beq_w4: got %h want %h", act_vec, exp); end
        drive(32'h0, 10'd0, 32'd0, 32'h0, 1'b0, 1'b0, 1'b1, 5'd6, 32'h0000_0066);
        clock_edge();
        exp = exp_q.pop_front(); n_tests++;
        if (act_vec !== exp) begin n_fail++; $display("FAIL beq_w6: got %h want %h", act_vec, exp); end
        drive(32'hFE62_0EE3, 10'b0001000001, 32'hFFFF_FFFC, 32'h300, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0);
        clock_edge();
        exp = exp_q.pop_front(); n_tests++;
        if (act_vec !== exp) begin n_fail++; $display("FAIL beq: got %h want %h", act_vec, exp); end
        n_tests++;
        if (Imm_Ext_E !== 32'hFFFF_FFFC || BranchE !== 1'b1) begin
            n_fail++; $display("FAIL beq_imm: got %h br=%b want fffffffc br=1", Imm_Ext_E, BranchE);
        end
    endtask

    task automatic test_flush();
        drive(32'h0062_A223, 10'b0110000000, 32'd4, 32'h400, 1'b1, 1'b0, 1'b0, 5'd0, 32'd0);
        clock_edge();
        exp = exp_q.pop_front(); n_tests++;
        if (act_vec !== exp) begin n_fail++; $display("FAIL flush_bubble: got %h want %h", act_vec, exp); end
        drive(32'h0062_A223, 10'b0110000000, 32'd4, 32'h400, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0);
        clock_edge();
        exp = exp_q.pop_front(); n_tests++;
        if (act_vec !== exp) begin n_fail++; $display("FAIL flush_release: got %h want %h", act_vec, exp); end
        n_tests++;
        if (MemWriteE !== 1'b1 || Imm_Ext_E !== 32'd4) begin
            n_fail++; $display("FAIL sw_fields: got mw=%b imm=%h want mw=1 imm=4", MemWriteE, Imm_Ext_E);
        end
    endtask

    task automatic test_x0();
        drive(32'h0, 10'd0, 32'd0, 32'h0, 1'b0, 1'b0, 1'b1, 5'd0, 32'hDEAD_BEEF);
        clock_edge();
        exp = exp_q.pop_front(); n_tests++;
        if (act_vec !== exp) begin n_fail++; $display("FAIL x0_write: got %h want %h", act_vec, exp); end
        drive(32'h0000_0093, 10'b1010000000, 32'd0, 32'h500, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0);
        clock_edge();
        exp = exp_q.pop_front(); n_tests++;
        if (act_vec !== exp) begin n_fail++; $display("FAIL x0_read: got %h want %h", act_vec, exp); end
        n_tests++;
        if (RD1_E !== 32'd0) begin n_fail++; $display("FAIL x0_rd1: got %h want 0", RD1_E); end
    endtask

    task automatic test_collision();
        logic [31:0] want;
`ifdef REGFILE_BYPASS_EN
        want = 32'h0000_1234;
`else
        want = 32'h0000_0099;
`endif
        drive(32'h0, 10'd0, 32'd0, 32'h0, 1'b0, 1'b0, 1'b1, 5'd7, 32'h0000_0099);
        clock_edge();
        exp = exp_q.pop_front(); n_tests++;
        if (act_vec !== exp) begin n_fail++; $display("FAIL coll_w7: got %h want %h", act_vec, exp); end
        drive(32'h0003_8433, 10'b1000000000, 32'd0, 32'h600, 1'b0, 1'b0, 1'b1, 5'd7, 32'h0000_1234);
        clock_edge();
        exp = exp_q.pop_front(); n_tests++;
        if (act_vec !== exp) begin n_fail++; $display("FAIL collision: got %h want %h", act_vec, exp); end
        n_tests++;
        if (RD1_E !== want) begin n_fail++; $display("FAIL coll_rd1: got %h want %h", RD1_E, want); end
        drive(32'h0003_8433, 10'b1000000000, 32'd0, 32'h604, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0);
        clock_edge();
        exp = exp_q.pop_front(); n_tests++;
        if (RD1_E !== 32'h0000_1234 || act_vec !== exp) begin
            n_fail++; $display("FAIL coll_after: got %h want %h", act_vec, exp);
        end
    endtask

    task automatic test_alu_table();
        for (int i = 0; i < 11; i++) begin
            drive(tbl_instr[i], tbl_ctrl[i], tbl_imm[i], $urandom() & 32'hFFFF_FFFC,
                  1'b0, 1'b0, 1'b0, 5'd0, 32'd0);
            clock_edge();
            exp = exp_q.pop_front(); n_tests++;
            if (act_vec !== exp) begin n_fail++; $display("FAIL decode[%0d] %h: got %h want %h", i, tbl_instr[i], act_vec, exp); end
        end
        drive(32'h1234_52B7, 10'd0, 32'h0000_0123, 32'h700, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0);
        clock_edge();
        exp = exp_q.pop_front(); n_tests++;
        if (act_vec !== exp) begin n_fail++; $display("FAIL decode_unknown: got %h want %h", act_vec, exp); end
    endtask

    task automatic test_back_to_back();
        int k;
        for (int i = 0; i < 60; i++) begin
            k = $urandom_range(0, 10);
            drive(tbl_instr[k], tbl_ctrl[k], tbl_imm[k], $urandom(), ($urandom_range(0, 7) == 0),
                  1'b0, 1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), $urandom());
            clock_edge();
            exp = exp_q.pop_front(); n_tests++;
            if (act_vec !== exp) begin n_fail++; $display("FAIL b2b[%0d]: got %h want %h", i, act_vec, exp); end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not complete in time");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; InstrD = '0; PCD = '0; PCPlus4D = '0; FlushE = 1'b0;
        RegWriteW = 1'b0; RDW = '0; ResultW = '0;
        for (int i = 0; i < 32; i++) ref_rf[i] = 32'd0;
        init_table();
        test_reset();
        test_addi();
        test_beq();
        test_flush();
        test_x0();
        test_collision();
        test_alu_table();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/decode_cycle.md
Name: decode_cycle

Overview:
Decode stage of the 5-stage RV32I pipeline. It sits directly downstream of fetch and consumes InstrD, PCD and PCPlus4D. It contains the 32x32 register file, the main/ALU control decoder and the immediate extender. All decoded values are registered into the ID/EX pipeline register, which feeds execute. It also exports source and destination register indices for the hazard unit.

Parameters:
XLEN, 32, datapath width
REG_COUNT, 32, architectural registers; x0 hard-wired zero

Ports:
clk  in  1  pipeline clock
rst  in  1  synchronous, active-high reset
InstrD  in  32  instruction from fetch
PCD  in  32  PC of InstrD
PCPlus4D  in  32  PCD+4
RegWriteW  in  1  writeback enable
RDW  in  5  writeback destination
ResultW  in  32  writeback data
FlushE  in  1  insert bubble into ID/EX
Rs1D, Rs2D  out  5 each  combinational rs1/rs2 fields of InstrD, for the hazard unit
RegWriteE, MemWriteE, ALUSrcE, BranchE, JumpE  out  1 each  registered control
ResultSrcE  out  2  00 ALU, 01 memory, 10 PC+4
ALUControlE  out  3  000 add, 001 sub, 010 and, 011 or, 101 slt
RD1_E, RD2_E, Imm_Ext_E, PCE, PCPlus4E  out  32 each  registered data
RS1_E, RS2_E, RD_E  out  5 each  registered register indices

Behaviour:
- Reset is synchronous and active-high. Clock is clk, reset is rst. On a clk rising edge with rst=1:
  - all *E outputs go to 0;
  - all 32 register-file entries go to 0.
- Reset has priority over FlushE and over writeback.
- Latency: decode is combinational from InstrD. The ID/EX register captures on every clk rising edge, so values appear on the E outputs exactly 1 cycle later. There is no stall input; a stalled decode is held upstream by fetch.
- FlushE=1 (rst=0) at an edge: all *E outputs load 0 (bubble). Flush has priority over normal capture.
- Register file:
  - writes ResultW to RDW on a clk rising edge when RegWriteW=1 and RDW!=0;
  - writes to x0 are ignored, and reads of x0 always return 0;
  - reads are asynchronous on InstrD[19:15] and InstrD[24:20].
- Opcode decode (op=InstrD[6:0]):
  - 0000011 lw: RegWrite=1, ALUSrc=1, ResultSrc=01, ImmSrc=I, ALUOp=00
  - 0100011 sw: MemWrite=1, ALUSrc=1, ImmSrc=S, ALUOp=00
  - 0110011 R-type: RegWrite=1, ALUOp=10
  - 0010011 I-ALU: RegWrite=1, ALUSrc=1, ImmSrc=I, ALUOp=10
  - 1100011 beq: Branch=1, ImmSrc=B, ALUOp=01
  - 1101111 jal: RegWrite=1, Jump=1, ResultSrc=10, ImmSrc=J
  - Any other opcode, including the 0x00000000 bubble from fetch, drives all controls to 0 (no-op).
- ALU decode:
  - ALUOp=00 gives add; ALUOp=01 gives sub.
  - ALUOp=10 decodes by funct3:
    - 000: sub only when op[5]=1 and funct7[5]=1, else add;
    - 010: slt;
    - 110: or;
    - 111: and;
    - others: add.
- Immediates are sign-extended from InstrD[31]:
  - I = {20{i31}, i[31:20]}
  - S = {20{i31}, i[31:25], i[11:7]}
  - B = {20{i31}, i[7], i[30:25], i[11:8], 0}
  - J = {12{i31}, i[19:12], i[20], i[30:21], 0}
- RD_E comes from InstrD[11:7] regardless of opcode.
- Simultaneous write and read of the same register in one cycle: see Optional Feature.

Optional Feature:
Macro: REGFILE_BYPASS_EN
- Defined: on a read/write collision the register file returns the write data combinationally. If RegWriteW=1, RDW!=0 and RDW equals the read index, the read returns ResultW in the same cycle.
- Undefined: the read returns the old stored value, and the hazard unit must stall one cycle.

Decomposition:
- Shared package riscv_pkg holds:
  - opcode constants OP_LOAD, OP_STORE, OP_RTYPE, OP_ITYPE, OP_BRANCH, OP_JAL;
  - ImmSrc encodings IMM_I/S/B/J;
  - ALU control codes ALU_ADD/SUB/AND/OR/SLT;
  - ResultSrc codes.
- One natural sub-module: register_file (32x32, sync write, async read, bypass macro inside). Control decode and immediate extension stay inline.

Test Plan:
- rst=1 for 2 cycles after arbitrary writes -> all *E outputs 0; reading x1..x31 afterwards returns 0.
- Write x5=0x0000_00AA (RegWriteW=1, RDW=5), then InstrD=0x0052_8313 (addi x6,x5,5) -> next cycle RD1_E=0xAA, Imm_Ext_E=5, ALUSrcE=1, RegWriteE=1, RD_E=6, ALUControlE=000.
- InstrD=0xFE62_0EE3 (beq x4,x6,-4) -> BranchE=1, ALUControlE=001, Imm_Ext_E=0xFFFF_FFFC, RegWriteE=0.
- Valid sw 0x0062_A223 with FlushE=1 -> all E outputs 0. Next cycle with FlushE=0 -> MemWriteE=1, Imm_Ext_E=4.
- Write x0=0xDEAD_BEEF, then read rs1=x0 -> RD1_E=0.
- Same-cycle collision: RDW=7, ResultW=0x1234, InstrD reads x7 (stored value 0x99) -> RD1_E=0x1234 with REGFILE_BYPASS_EN defined, 0x99 without.
